can_timing_controller: RTL and testbench

Sequencer and configuration manager for the CAN bit timing unit (`bit_timing_configuration`). It generates the time-quantum strobe from a baud-rate prescaler, and it drives the unit's `enable` through an idle/run/drain state machine. It also validates host-supplied segment settings and commits them only on bit boundaries, so the timing unit never sees a mid-bit configuration change. It sits between the host register interface and the bit timing unit.

---
 rtl/can_timing_controller.sv | 250 +++++++++++++++++++++++++
 tb/tb_can_timing_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_timing_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : can_timing_controller                                           |
// | Desc     : Time-quantum prescaler, idle/run/drain sequencer and            |
// |            bit-boundary configuration commit for the CAN bit timing unit.  |
// | Options  : define CAN_TIMING_WATCHDOG_EN to add the tq watchdog and the    |
// |            sticky fault output (otherwise fault is tied low).              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module can_timing_controller #(
  parameter int BRP_W    = 6,
  parameter int DEF_BRP  = 0,
  parameter int DEF_PROP = 3,
  parameter int DEF_PH1  = 2,
  parameter int DEF_PH2  = 2
) (
  input  logic             clock,
  input  logic             reset,
  // host configuration port
  input  logic             cfg_req,
  input  logic [BRP_W-1:0] cfg_brp,
  input  logic [3:0]       cfg_prop_seg,
  input  logic [3:0]       cfg_phase_seg1,
  input  logic [3:0]       cfg_phase_seg2,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             cfg_pending,
  // run control
  input  logic             start,
  input  logic             stop,
  // bit timing unit handshake
  input  logic             bit_timing_end,
  output logic             tq_pulse,
  output logic             enable,
  output logic [3:0]       prop_seg,
  output logic [3:0]       phase_seg1,
  output logic [3:0]       phase_seg2,
  output logic [1:0]       state,
  output logic             fault
);

  localparam logic [BRP_W-1:0] C_DEF_BRP  = BRP_W'(DEF_BRP);
  localparam logic [3:0]       C_DEF_PROP = 4'(DEF_PROP);
  localparam logic [3:0]       C_DEF_PH1  = 4'(DEF_PH1);
  localparam logic [3:0]       C_DEF_PH2  = 4'(DEF_PH2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // sequencer and prescaler
  state_e           state_q, state_d;
  logic             enable_q, enable_d;
  logic             tq_pulse_q, tq_pulse_d;
  logic [BRP_W-1:0] cnt_q, cnt_d;

  // host handshake strobes
  logic             cfg_ack_q, cfg_ack_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_pending_q, cfg_pending_d;

  // accepted-but-uncommitted configuration
  logic [BRP_W-1:0] pend_brp_q, pend_brp_d;
  logic [3:0]       pend_prop_q, pend_prop_d;
  logic [3:0]       pend_ph1_q, pend_ph1_d;
  logic [3:0]       pend_ph2_q, pend_ph2_d;

  // configuration currently seen by the timing unit
  logic [BRP_W-1:0] brp_q, brp_d;
  logic [3:0]       prop_q, prop_d;
  logic [3:0]       ph1_q, ph1_d;
  logic [3:0]       ph2_q, ph2_d;

  logic [5:0]       cfg_total;
  logic             cfg_valid;
  logic             commit;
  logic             fault_int;

`ifdef CAN_TIMING_WATCHDOG_EN
  logic [4:0]       wd_q, wd_d;
  logic             fault_q, fault_d;
  assign fault_int = fault_q;
`else
  assign fault_int = 1'b0;
`endif

  assign fault       = fault_int;
  assign enable      = enable_q;
  assign tq_pulse    = tq_pulse_q;
  assign state       = state_q;
  assign cfg_ack     = cfg_ack_q;
  assign cfg_err     = cfg_err_q;
  assign cfg_pending = cfg_pending_q;
  assign prop_seg    = prop_q;
  assign phase_seg1  = ph1_q;
  assign phase_seg2  = ph2_q;

  // Segment range and total bit length check on the raw request inputs
  always_comb begin
    cfg_total = 6'd1 + {2'b00, cfg_prop_seg} + {2'b00, cfg_phase_seg1}
              + {2'b00, cfg_phase_seg2};
    cfg_valid = (cfg_prop_seg   >= 4'd1) && (cfg_prop_seg   <= 4'd8) &&
                (cfg_phase_seg1 >= 4'd1) && (cfg_phase_seg1 <= 4'd8) &&
                (cfg_phase_seg2 >= 4'd2) && (cfg_phase_seg2 <= 4'd8) &&
                (cfg_total >= 6'd8) && (cfg_total <= 6'd25);
  end

  // Next-state for config capture/commit, sequencer and prescaler
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tq_pulse_d    = 1'b0;
    cfg_ack_d     = 1'b0;
    cfg_err_d     = 1'b0;
    cfg_pending_d = cfg_pending_q;
    pend_brp_d    = pend_brp_q;
    pend_prop_d   = pend_prop_q;
    pend_ph1_d    = pend_ph1_q;
    pend_ph2_d    = pend_ph2_q;
    brp_d         = brp_q;
    prop_d        = prop_q;
    ph1_d         = ph1_q;
    ph2_d         = ph2_q;

    // While running, a change may only land at the end of a bit.
    commit = cfg_pending_q && ((state_q == ST_IDLE) || bit_timing_end);

    // Capture and commit are exclusive: capture needs an empty slot,
    // commit needs a full one.
    if (cfg_req) begin
      if (!cfg_valid || cfg_pending_q) begin
        cfg_err_d = 1'b1;
      end else begin
        cfg_pending_d = 1'b1;
        pend_brp_d    = cfg_brp;
        pend_prop_d   = cfg_prop_seg;
        pend_ph1_d    = cfg_phase_seg1;
        pend_ph2_d    = cfg_phase_seg2;
      end
    end

    if (commit) begin
      cfg_pending_d = 1'b0;
      cfg_ack_d     = 1'b1;
      brp_d         = pend_brp_q;
      prop_d        = pend_prop_q;
      ph1_d         = pend_ph1_q;
      ph2_d         = pend_ph2_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && !stop && !fault_int) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (cnt_q == brp_q) begin
          cnt_d      = '0;
          tq_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + BRP_W'(1);
        end
        if (fault_int) begin
          state_d = ST_IDLE;
        end else if ((state_q == ST_RUN) && stop) begin
          state_d = ST_DRAIN;
        end else if ((state_q == ST_DRAIN) && bit_timing_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Leaving the run states drops any pulse due on the first idle cycle;
    // a commit restarts the quantum so the new prescaler starts aligned.
    if ((state_d == ST_IDLE) || commit) begin
      cnt_d      = '0;
      tq_pulse_d = 1'b0;
    end

    enable_d = (state_d != ST_IDLE);
  end

`ifdef CAN_TIMING_WATCHDOG_EN
  // Count quanta since the last bit end; 26 without one means the unit is stuck
  always_comb begin
    wd_d    = wd_q;
    fault_d = fault_q;
    if ((state_q == ST_IDLE) || bit_timing_end) begin
      wd_d = '0;
    end else if (tq_pulse_q) begin
      wd_d = wd_q + 5'd1;
      if (wd_q == 5'd25) begin
        fault_d = 1'b1;
      end
    end
  end
`endif

  // Register all state; reset restores defaults and drops any pending config
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      tq_pulse_q    <= 1'b0;
      cnt_q         <= '0;
      cfg_ack_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      cfg_pending_q <= 1'b0;
      pend_brp_q    <= C_DEF_BRP;
      pend_prop_q   <= C_DEF_PROP;
      pend_ph1_q    <= C_DEF_PH1;
      pend_ph2_q    <= C_DEF_PH2;
      brp_q         <= C_DEF_BRP;
      prop_q        <= C_DEF_PROP;
      ph1_q         <= C_DEF_PH1;
      ph2_q         <= C_DEF_PH2;
`ifdef CAN_TIMING_WATCHDOG_EN
      wd_q          <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      tq_pulse_q    <= tq_pulse_d;
      cnt_q         <= cnt_d;
      cfg_ack_q     <= cfg_ack_d;
      cfg_err_q     <= cfg_err_d;
      cfg_pending_q <= cfg_pending_d;
      pend_brp_q    <= pend_brp_d;
      pend_prop_q   <= pend_prop_d;
      pend_ph1_q    <= pend_ph1_d;
      pend_ph2_q    <= pend_ph2_d;
      brp_q         <= brp_d;
      prop_q        <= prop_d;
      ph1_q         <= ph1_d;
      ph2_q         <= ph2_d;
`ifdef CAN_TIMING_WATCHDOG_EN
      wd_q          <= wd_d;
      fault_q       <= fault_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_timing_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_can_timing_controller                                        |
// | Desc     : Directed stimulus with a cycle-level reference model and        |
// |            literal spot checks for can_timing_controller.                  |
// | Options  : honours CAN_TIMING_WATCHDOG_EN like the design.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_can_timing_controller;

`ifdef CAN_TIMING_WATCHDOG_EN
  localparam int WD_EN = 1;
`else
  localparam int WD_EN = 0;
`endif

  logic       clock;
  logic       reset;
  logic       cfg_req;
  logic [5:0] cfg_brp;
  logic [3:0] cfg_prop_seg, cfg_phase_seg1, cfg_phase_seg2;
  logic       cfg_ack, cfg_err, cfg_pending;
  logic       start, stop, bit_timing_end;
  logic       tq_pulse, enable;
  logic [3:0] prop_seg, phase_seg1, phase_seg2;
  logic [1:0] state;
  logic       fault;

  int checks = 0;
  int errors = 0;

  can_timing_controller dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_req        (cfg_req),
    .cfg_brp        (cfg_brp),
    .cfg_prop_seg   (cfg_prop_seg),
    .cfg_phase_seg1 (cfg_phase_seg1),
    .cfg_phase_seg2 (cfg_phase_seg2),
    .cfg_ack        (cfg_ack),
    .cfg_err        (cfg_err),
    .cfg_pending    (cfg_pending),
    .start          (start),
    .stop           (stop),
    .bit_timing_end (bit_timing_end),
    .tq_pulse       (tq_pulse),
    .enable         (enable),
    .prop_seg       (prop_seg),
    .phase_seg1     (phase_seg1),
    .phase_seg2     (phase_seg2),
    .state          (state),
    .fault          (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string nm, input logic [7:0] act, input int exp);
    checks++;
    if (act !== 8'(exp)) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected outputs for the current cycle. The tq pulse is derived from the
  // cycle index relative to the last point the quantum restarted (run entry
  // or commit): a pulse falls on every (brp+1)-th cycle after that origin.
  int cyc = 0;
  bit model_ok = 0;
  int m_state, m_brp, m_prop, m_ph1, m_ph2, m_wd, origin;
  int q_brp, q_prop, q_ph1, q_ph2;
  bit m_tq, m_ack, m_err, m_pend, m_fault;

  function automatic bit spec_valid(input int p, input int a, input int b);
    int tot;
    tot = 1 + p + a + b;
    return (p >= 1 && p <= 8 && a >= 1 && a <= 8 && b >= 2 && b <= 8 &&
            tot >= 8 && tot <= 25);
  endfunction

  always @(posedge clock) begin : model
    int c, n_state;
    bit ok, commit, n_pend, n_err, n_ack, n_fault;
    c = cyc;
    if (reset) begin
      m_state = 0; m_tq = 0; m_ack = 0; m_err = 0; m_pend = 0; m_fault = 0;
      m_brp = 0; m_prop = 3; m_ph1 = 2; m_ph2 = 2; m_wd = 0; origin = 0;
    end else begin
      ok     = spec_valid(int'(cfg_prop_seg), int'(cfg_phase_seg1), int'(cfg_phase_seg2));
      commit = m_pend && (m_state == 0 || bit_timing_end);
      n_err  = cfg_req && (!ok || m_pend);
      n_ack  = commit;
      n_pend = m_pend;
      if (commit) begin
        n_pend = 0;
        m_brp = q_brp; m_prop = q_prop; m_ph1 = q_ph1; m_ph2 = q_ph2;
        origin = c + 1;
      end else if (cfg_req && ok && !m_pend) begin
        n_pend = 1;
        q_brp = int'(cfg_brp); q_prop = int'(cfg_prop_seg);
        q_ph1 = int'(cfg_phase_seg1); q_ph2 = int'(cfg_phase_seg2);
      end
      n_state = m_state;
      case (m_state)
        0: if (start && !stop && !m_fault) begin n_state = 1; origin = c + 1; end
        1: if (m_fault) n_state = 0; else if (stop) n_state = 2;
        default: if (m_fault || bit_timing_end) n_state = 0;
      endcase
      n_fault = m_fault;
      if (WD_EN != 0) begin
        if (m_state == 0 || bit_timing_end) m_wd = 0;
        else if (m_tq) begin
          m_wd = m_wd + 1;
          if (m_wd == 26) n_fault = 1;
        end
      end
      m_tq = (n_state != 0) && (c + 1 > origin) && (((c + 1 - origin) % (m_brp + 1)) == 0);
      m_state = n_state; m_pend = n_pend; m_err = n_err; m_ack = n_ack; m_fault = n_fault;
    end
    cyc = c + 1;
    model_ok = 1;
  end

  // Compare every cycle, mid-way between rising edges
  always @(negedge clock) begin
    if (model_ok) begin
      cmp("m_state",   {6'b0, state},  m_state);
      cmp("m_enable",  {7'b0, enable}, (m_state != 0) ? 1 : 0);
      cmp("m_tq",      {7'b0, tq_pulse},    int'(m_tq));
      cmp("m_ack",     {7'b0, cfg_ack},     int'(m_ack));
      cmp("m_err",     {7'b0, cfg_err},     int'(m_err));
      cmp("m_pending", {7'b0, cfg_pending}, int'(m_pend));
      cmp("m_prop",    {4'b0, prop_seg},    m_prop);
      cmp("m_ph1",     {4'b0, phase_seg1},  m_ph1);
      cmp("m_ph2",     {4'b0, phase_seg2},  m_ph2);
      cmp("m_fault",   {7'b0, fault},       int'(m_fault));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic cfg(input int b, input int p, input int a, input int s);
    cfg_req        = 1'b1;
    cfg_brp        = 6'(b);
    cfg_prop_seg   = 4'(p);
    cfg_phase_seg1 = 4'(a);
    cfg_phase_seg2 = 4'(s);
  endtask

  initial begin
    reset = 1'b1; cfg_req = 1'b0; cfg_brp = '0;
    cfg_prop_seg = '0; cfg_phase_seg1 = '0; cfg_phase_seg2 = '0;
    start = 1'b0; stop = 1'b0; bit_timing_end = 1'b0;
    tick; tick;
    reset = 1'b0;
    cmp("rst_state", {6'b0, state}, 0);
    cmp("rst_enable", {7'b0, enable}, 0);
    cmp("rst_prop", {4'b0, prop_seg}, 3);
    cmp("rst_ph2", {4'b0, phase_seg2}, 2);
    cmp("rst_pending", {7'b0, cfg_pending}, 0);

    // idle commit of brp=3, 3/2/2: pending at N+1, ack at N+2
    cfg(3, 3, 2, 2); tick; cfg_req = 1'b0;
    cmp("idle_pend", {7'b0, cfg_pending}, 1);
    tick;
    cmp("idle_ack", {7'b0, cfg_ack}, 1);

    // rejected requests
    cfg(3, 9, 1, 1); tick; cfg_req = 1'b0;
    cmp("err_prop9", {7'b0, cfg_err}, 1);
    cmp("err_prop9_keep", {4'b0, prop_seg}, 3);
    cfg(3, 3, 2, 1); tick; cfg_req = 1'b0;
    cmp("err_ph2_1", {7'b0, cfg_err}, 1);
    cfg(3, 1, 1, 2); tick; cfg_req = 1'b0;
    cmp("err_total5", {7'b0, cfg_err}, 1);
    tick;
    cmp("err_clear", {7'b0, cfg_err}, 0);

    // start with brp=3: enable at N+1, pulses at N+5, N+9, N+13
    start = 1'b1; tick; start = 1'b0;
    cmp("run_enable", {7'b0, enable}, 1);
    tick; tick; tick;
    cmp("tq_n4", {7'b0, tq_pulse}, 0);
    tick;
    cmp("tq_n5", {7'b0, tq_pulse}, 1);
    repeat (4) tick;
    cmp("tq_n9", {7'b0, tq_pulse}, 1);
    repeat (4) tick;
    cmp("tq_n13", {7'b0, tq_pulse}, 1);

    // mid-bit request waits for the bit end; a second one is rejected
    cfg(1, 3, 4, 5); tick;
    cfg(3, 4, 4, 4);
    cmp("run_pend", {7'b0, cfg_pending}, 1);
    tick; cfg_req = 1'b0;
    cmp("run_err2", {7'b0, cfg_err}, 1);
    tick; tick;
    cmp("run_hold", {4'b0, phase_seg2}, 2);
    bit_timing_end = 1'b1; tick; bit_timing_end = 1'b0;
    cmp("run_ack", {7'b0, cfg_ack}, 1);
    cmp("run_ph1", {4'b0, phase_seg1}, 4);
    cmp("run_ph2", {4'b0, phase_seg2}, 5);

    // stop -> DRAIN; the bit end lands where a pulse was due and drops it
    repeat (6) tick;
    stop = 1'b1; tick; stop = 1'b0;
    cmp("drain_state", {6'b0, state}, 2);
    tick;
    cmp("drain_tq", {7'b0, tq_pulse}, 1);
    tick;
    bit_timing_end = 1'b1; tick; bit_timing_end = 1'b0;
    cmp("drain_exit", {6'b0, state}, 0);
    cmp("drain_supp", {7'b0, tq_pulse}, 0);

    // start and stop together in IDLE; bit end ignored in IDLE
    start = 1'b1; stop = 1'b1; tick; start = 1'b0; stop = 1'b0;
    cmp("ss_idle", {6'b0, state}, 0);
    bit_timing_end = 1'b1; tick; bit_timing_end = 1'b0;
    tick;

    // maximum total (25 tq) with brp=0, committed in IDLE
    cfg(0, 8, 8, 8); tick; cfg_req = 1'b0; tick;
    cmp("max_ack", {7'b0, cfg_ack}, 1);
    cmp("max_prop", {4'b0, prop_seg}, 8);

    // brp=0: pulse every cycle from N+2
    start = 1'b1; tick; start = 1'b0;
    tick;
    cmp("brp0_n2", {7'b0, tq_pulse}, 1);
    tick;
    cmp("brp0_n3", {7'b0, tq_pulse}, 1);
    // commit and drain exit on the same bit end
    cfg(2, 3, 2, 2); tick; cfg_req = 1'b0;
    stop = 1'b1; tick; stop = 1'b0;
    cmp("dual_pend", {7'b0, cfg_pending}, 1);
    bit_timing_end = 1'b1; tick; bit_timing_end = 1'b0;
    cmp("dual_state", {6'b0, state}, 0);
    cmp("dual_ack", {7'b0, cfg_ack}, 1);
    cmp("dual_prop", {4'b0, prop_seg}, 3);

    // reset mid-operation drops pending and restores defaults
    start = 1'b1; tick; start = 1'b0;
    cfg(4, 8, 8, 8); tick; cfg_req = 1'b0;
    reset = 1'b1; tick; reset = 1'b0;
    cmp("mrst_state", {6'b0, state}, 0);
    cmp("mrst_pend", {7'b0, cfg_pending}, 0);
    cmp("mrst_ph1", {4'b0, phase_seg1}, 2);

    // run with no bit end: brp=0 gives the 26th pulse at N+27
    start = 1'b1; tick; start = 1'b0;
    repeat (27) tick;
    cmp("wd_fault", {7'b0, fault}, WD_EN);
    cmp("wd_state_n28", {6'b0, state}, 1);
    tick;
    cmp("wd_state_n29", {6'b0, state}, (WD_EN != 0) ? 0 : 1);
    stop = 1'b1; tick; stop = 1'b0;
    bit_timing_end = 1'b1; tick; bit_timing_end = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    cmp("wd_block", {6'b0, state}, (WD_EN != 0) ? 0 : 1);
    reset = 1'b1; tick; reset = 1'b0;
    cmp("wd_rst", {7'b0, fault}, 0);
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
